// File: rtl/cordic_rotation_scheduler.sv
// Round-robin scheduler sharing one iterative CORDIC rotation engine between NUM_REQ requesters.
// Optional engine watchdog enabled by defining CORDIC_SCHED_TIMEOUT_EN.
module cordic_rotation_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_x,
    input  logic [NUM_REQ*16-1:0]   req_y,
    input  logic [NUM_REQ*16-1:0]   req_phi,
    output logic                    eng_start,
    output logic [15:0]             eng_x,
    output logic [15:0]             eng_y,
    output logic [15:0]             eng_phi,
    input  logic                    eng_done,
    input  logic [15:0]             eng_x_res,
    input  logic [15:0]             eng_y_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             rsp_x,
    output logic [15:0]             rsp_y,
    output logic                    rsp_err,
    output logic                    busy
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 ||
        ID_W != (($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1)) begin : g_bad_params
        $error("cordic_rotation_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic            grant_vld;
    logic            timeout_hit;

    logic [15:0] op_x   [NUM_REQ];
    logic [15:0] op_y   [NUM_REQ];
    logic [15:0] op_phi [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_x[i]   = req_x[16*i +: 16];
        assign op_y[i]   = req_y[16*i +: 16];
        assign op_phi[i] = req_phi[16*i +: 16];
    end

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = last_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign eng_start = (state_q == StIssue);
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_vld) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (eng_done || timeout_hit) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] wait_cnt;

    // Fires on the WAIT cycle that brings the count up to TIMEOUT_CYC.
    assign timeout_hit = (state_q == StWait) && !eng_done &&
                         (wait_cnt == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state_q == StIssue) begin
                wait_cnt <= '0;
            end else if (state_q == StWait) begin
                wait_cnt <= wait_cnt + CntW'(1);
            end
            if (timeout_hit) begin
                rsp_err <= 1'b1;
            end else if (state_q == StResp && rsp_ready) begin
                rsp_err <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= ID_W'(NUM_REQ - 1);
            eng_x     <= '0;
            eng_y     <= '0;
            eng_phi   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && grant_vld) begin
                last_q  <= grant_idx;
                eng_x   <= op_x[grant_idx];
                eng_y   <= op_y[grant_idx];
                eng_phi <= op_phi[grant_idx];
            end
            if (state_q == StWait && eng_done) begin
                rsp_valid <= 1'b1;
                rsp_id    <= last_q;
                rsp_x     <= eng_x_res;
                rsp_y     <= eng_y_res;
            end else if (timeout_hit) begin
                rsp_valid <= 1'b1;
                rsp_id    <= last_q;
                rsp_x     <= '0;
                rsp_y     <= '0;
            end
            if (state_q == StResp && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_rotation_scheduler.sv
// Randomised self-checking bench for cordic_rotation_scheduler with a transaction-level model
// and a behavioural CORDIC engine stand-in.
module tb_cordic_rotation_scheduler;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*16-1:0]  req_x, req_y, req_phi;
    logic              eng_start;
    logic [15:0]       eng_x, eng_y, eng_phi;
    logic              eng_done;
    logic [15:0]       eng_x_res, eng_y_res;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_x, rsp_y;
    logic              rsp_err, busy;

    always #5 clk = ~clk;

    cordic_rotation_scheduler #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_phi(req_phi),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_phi(eng_phi),
        .eng_done(eng_done), .eng_x_res(eng_x_res), .eng_y_res(eng_y_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: m_step 0 = free, 1 = just granted, 2 = engine running, 3 = holding a result.
    int          m_step, m_last, m_rid, m_wait;
    logic [15:0] m_ox, m_oy, m_ophi, m_rx, m_ry;
    bit          m_rv, m_err;

    // Engine stand-in and directed knobs.
    int          eng_cnt = 0;
    logic [15:0] pend_x, pend_y;
    int          lat_fixed = 0;
    bit          res_fixed = 0, eng_dead = 0, spur_en = 0, force_done = 0;

    int          start_cnt;
    int          ready_cnt [NR];
    int          grant_log [$];
    int          rsp_log [$];
    logic [15:0] rspx_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_step = 0; m_last = NR - 1; m_rid = 0; m_wait = 0;
        m_ox = 0; m_oy = 0; m_ophi = 0; m_rx = 0; m_ry = 0; m_rv = 0; m_err = 0;
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= NR; k++) begin
            if (req_valid[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    task automatic clear_obs();
        start_cnt = 0;
        for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
        grant_log.delete(); rsp_log.delete(); rspx_log.delete();
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] phi);
        req_x[16*i +: 16] = x; req_y[16*i +: 16] = y; req_phi[16*i +: 16] = phi;
    endtask

    // One clock: engine drives at negedge, outputs checked 1 ns later, model advances.
    task automatic tick();
        int g;
        logic [NR-1:0] exp_ready;
        @(negedge clk);
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done = 1'b1; eng_x_res = pend_x; eng_y_res = pend_y;
            end
        end else if (force_done || (spur_en && m_step != 2 && $urandom_range(0, 7) == 0)) begin
            eng_done = 1'b1; eng_x_res = 16'($urandom); eng_y_res = 16'($urandom);
        end
        #1;
        g = model_grant();
        exp_ready = '0;
        if (m_step == 0 && g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(m_step != 0));
        chk("eng_start", 32'(eng_start), 32'(m_step == 1));
        chk("eng_x", 32'(eng_x), 32'(m_ox));
        chk("eng_y", 32'(eng_y), 32'(m_oy));
        chk("eng_phi", 32'(eng_phi), 32'(m_ophi));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        if (m_rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_rid));
            chk("rsp_x", 32'(rsp_x), 32'(m_rx));
            chk("rsp_y", 32'(rsp_y), 32'(m_ry));
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                ready_cnt[i]++; grant_log.push_back(i);
            end
        end
        if (rsp_valid && rsp_ready) begin
            rsp_log.push_back(int'(rsp_id)); rspx_log.push_back(rsp_x);
        end
        if (eng_start) begin
            start_cnt++;
            if (!eng_dead) begin
                eng_cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 12));
                pend_x  = res_fixed ? 16'h2D41 : (eng_x ^ eng_phi);
                pend_y  = res_fixed ? 16'h2D41 : (eng_y + eng_phi);
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            case (m_step)
                0: if (g >= 0) begin
                    m_ox = req_x[16*g +: 16]; m_oy = req_y[16*g +: 16];
                    m_ophi = req_phi[16*g +: 16]; m_last = g; m_step = 1;
                end
                1: begin m_step = 2; m_wait = 0; end
                2: if (eng_done) begin
                    m_rv = 1; m_rid = m_last; m_rx = eng_x_res; m_ry = eng_y_res; m_step = 3;
                end else begin
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    m_wait++;
                    if (m_wait == TO) begin
                        m_rv = 1; m_rid = m_last; m_rx = 0; m_ry = 0; m_err = 1; m_step = 3;
                    end
`endif
                end
                3: if (rsp_ready) begin m_rv = 0; m_err = 0; m_step = 0; end
                default: m_step = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    initial begin
        bit ok;
        int n, snap_start;
        logic [15:0] snap_x;
        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_phi = '0;
        eng_done = 1'b0; eng_x_res = '0; eng_y_res = '0; rsp_ready = 1'b0;
        model_reset(); clear_obs();
        do_reset();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_eng_x", 32'(eng_x), 32'd0);

        // Single request on requester 0 with a fixed 9-cycle engine.
        clear_obs(); lat_fixed = 9; res_fixed = 1; rsp_ready = 1'b1;
        set_req(0, 16'h4000, 16'h0000, 16'h2000); req_valid = 4'b0001;
        tick(); req_valid = '0;
        for (n = 0; n < 40 && rsp_log.size() == 0; n++) tick();
        chk("t1_resp_seen", 32'(rsp_log.size()), 32'd1);
        chk("t1_ready_pulses", 32'(ready_cnt[0]), 32'd1);
        chk("t1_start_pulses", 32'(start_cnt), 32'd1);
        if (rsp_log.size() > 0) begin
            chk("t1_rsp_id", 32'(rsp_log[0]), 32'd0);
            chk("t1_rsp_x", 32'(rspx_log[0]), 32'h2D41);
        end
        chk("t1_latency", 32'(n), 32'd11);

        // All requesters valid from reset: grant order 0,1,2,3,0.
        do_reset(); clear_obs(); res_fixed = 0; lat_fixed = 0;
        for (int i = 0; i < NR; i++) set_req(i, 16'(16'h1100 * (i + 1)), 16'(16'h0230 + i), 16'(16'h0F0F << i));
        req_valid = '1;
        for (n = 0; n < 300 && rsp_log.size() < 5; n++) tick();
        req_valid = '0;
        chk("t2_resp_count", 32'(rsp_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < rsp_log.size() && k < grant_log.size(); k++) begin
            chk("t2_grant_order", 32'(grant_log[k]), 32'(k % NR));
            chk("t2_rsp_id_order", 32'(rsp_log[k]), 32'(k % NR));
            chk("t2_rsp_x", 32'(rspx_log[k]), 32'((16'h1100 * (k % NR + 1)) ^ (16'h0F0F << (k % NR))));
        end
        for (n = 0; n < 40 && busy; n++) tick();

        // Response back-pressure: held five cycles with every requester asking.
        clear_obs(); rsp_ready = 1'b0; req_valid = 4'b0100;
        tick(); req_valid = '0;
        for (n = 0; n < 40 && !rsp_valid; n++) tick();
        chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        snap_x = rsp_x; snap_start = start_cnt; req_valid = '1;
        for (int k = 0; k < 5; k++) tick();
        chk("t3_rsp_x_stable", 32'(rsp_x), 32'(snap_x));
        chk("t3_no_restart", 32'(start_cnt), 32'(snap_start));
        chk("t3_no_ready", 32'(ready_cnt[0] + ready_cnt[1] + ready_cnt[3]), 32'd0);
        req_valid = '0; rsp_ready = 1'b1; tick();

        // Reset during WAIT; the late eng_done must be ignored.
        clear_obs(); lat_fixed = 8; req_valid = 4'b0010;
        tick(); req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t4_no_resp", 32'(rsp_log.size()), 32'd0);

        // Spurious eng_done in IDLE.
        force_done = 1; tick(); force_done = 0; tick();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);

        // Randomised traffic with back-pressure, spurious dones and occasional resets.
        lat_fixed = 0; spur_en = 1;
        for (int c = 0; c < 1500; c++) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) set_req(i, 16'($urandom), 16'($urandom), 16'($urandom));
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; spur_en = 0; req_valid = '0; rsp_ready = 1'b1;
        for (n = 0; n < 60 && (busy || eng_cnt > 0); n++) tick();

`ifdef CORDIC_SCHED_TIMEOUT_EN
        // Engine never answers: watchdog abort after 16 WAIT cycles.
        clear_obs(); eng_dead = 1; rsp_ready = 1'b0; req_valid = 4'b1000;
        tick(); req_valid = '0; tick();
        for (n = 0; n < 40 && !rsp_valid; n++) tick();
        chk("t7_wait_cycles", 32'(n), 32'd16);
        chk("t7_err", 32'(rsp_err), 32'd1);
        chk("t7_x", 32'(rsp_x), 32'd0);
        chk("t7_y", 32'(rsp_y), 32'd0);
        rsp_ready = 1'b1; tick();
        chk("t7_err_clear", 32'(rsp_err), 32'd0);
        eng_dead = 0;
`endif
        ok = (n_chk > 0);
        if (!ok) $display("FAIL no_checks: got %0d, expected >0", n_chk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
